// File: rtl/demux16_collect.sv
// demux16_collect: rebuilds 16-bit words from a select/enable serial stream.
// Bits land in an assembly register by lane (addressed or auto-pointer); a
// full word moves to a valid/ready output register, stalling if it is busy.
module demux16_collect (
    input  logic        clock,
    input  logic        reset,
    input  logic        din,
    input  logic [3:0]  sel,
    input  logic        en,
    input  logic        auto,
    input  logic        flush,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        dup_err
);

    logic [15:0] asm_q;
    logic [15:0] mask_q;
    logic [3:0]  ptr_q;

    logic [15:0] asm_d;
    logic [15:0] mask_d;
    logic [3:0]  ptr_d;
    logic [15:0] out_data_d;
    logic        out_valid_d;
    logic        dup_err_d;

    logic [3:0]  lane;
    logic        accept;
    logic        slot_free;
    logic        complete;
    logic [15:0] asm_w;
    logic [15:0] mask_w;

    // A full mask means a finished word is waiting for the output slot.
    assign in_ready = (mask_q != 16'hFFFF);

    // Next-state: merge the accepted bit, then decide transfer, flush or hold.
    always_comb begin
        lane      = auto ? ptr_q : sel;
        accept    = en && in_ready && !flush;
        slot_free = !out_valid || out_ready;

        asm_w  = asm_q;
        mask_w = mask_q;
        if (accept) begin
            asm_w[lane]  = din;
            mask_w[lane] = 1'b1;
        end
        // Also true for a word already stalled with no new write.
        complete = (mask_w == 16'hFFFF);

        asm_d       = asm_w;
        mask_d      = mask_w;
        ptr_d       = (accept && auto) ? ptr_q + 4'd1 : ptr_q;
        out_data_d  = out_data;
        out_valid_d = out_valid && !out_ready;
        dup_err_d   = dup_err || (accept && mask_q[lane]);

        if (flush) begin
            // Partial or stalled word is dropped; output side keeps draining.
            asm_d  = asm_q;
            mask_d = 16'h0000;
            ptr_d  = 4'd0;
        end else if (complete && slot_free) begin
            // Load replaces a word being drained on this same edge, so no bubble.
            out_data_d  = asm_w;
            out_valid_d = 1'b1;
            mask_d      = 16'h0000;
            ptr_d       = 4'd0;
        end
    end

    // State registers with synchronous reset overriding everything else.
    always_ff @(posedge clock) begin
        if (reset) begin
            asm_q     <= 16'h0000;
            mask_q    <= 16'h0000;
            ptr_q     <= 4'd0;
            out_data  <= 16'h0000;
            out_valid <= 1'b0;
            dup_err   <= 1'b0;
        end else begin
            asm_q     <= asm_d;
            mask_q    <= mask_d;
            ptr_q     <= ptr_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            dup_err   <= dup_err_d;
        end
    end

endmodule

// File: tb/tb_demux16_collect.sv
// Bench for demux16_collect: expected words queued as stimulus is driven and
// compared by a monitor at each output handshake; tasks check control flags.
module tb_demux16_collect;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        din = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic        en = 1'b0;
    logic        auto = 1'b0;
    logic        flush = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        dup_err;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    demux16_collect dut (
        .clock(clock), .reset(reset), .din(din), .sel(sel), .en(en),
        .auto(auto), .flush(flush), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .dup_err(dup_err)
    );

    always #5 clock = ~clock;

    // Scoreboard: a handshake will occur on the next rising edge.
    always @(negedge clock) begin
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL word_unexpected: got %h, none expected", out_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    failures++;
                    $display("FAIL word_data: got %h, expected %h", out_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic d, input logic [3:0] s, input logic a);
        din = d; sel = s; auto = a; en = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        checks++;
        if ({out_valid, out_data, dup_err, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: got v=%b d=%h e=%b r=%b, expected v=0 d=0000 e=0 r=1",
                     out_valid, out_data, dup_err, in_ready);
        end
    endtask

    task automatic test_auto_fill();
        logic [15:0] pat;
        pat = 16'h8F0D;
        out_ready = 1'b1;
        exp_q.push_back(16'h8F0D);
        for (int i = 0; i < 16; i++) begin
            drive(pat[i], 4'd0, 1'b1);
            if (i == 14) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL auto_early_valid: got %b, expected 0", out_valid);
                end
            end
        end
        en = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h8F0D) begin
            failures++;
            $display("FAIL auto_fill: got v=%b d=%h, expected v=1 d=8f0d", out_valid, out_data);
        end
        checks++;
        if (dup_err !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL auto_flags: got e=%b r=%b, expected e=0 r=1", dup_err, in_ready);
        end
        idle(1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL auto_drain: got v=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_addressed();
        out_ready = 1'b1;
        exp_q.push_back(16'h0210);
        for (int s = 15; s >= 0; s--)
            drive((s == 4 || s == 9), 4'(s), 1'b0);
        en = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0210 || dup_err !== 1'b0) begin
            failures++;
            $display("FAIL addressed: got v=%b d=%h e=%b, expected v=1 d=0210 e=0",
                     out_valid, out_data, dup_err);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [15:0] w0, w1;
        logic        stalled;
        w0 = 16'($urandom);
        w1 = 16'($urandom);
        stalled = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back(w0);
        exp_q.push_back(w1);
        for (int i = 0; i < 32; i++) begin
            if (in_ready !== 1'b1) stalled = 1'b1;
            drive((i < 16) ? w0[i] : w1[i - 16], 4'd0, 1'b1);
            if (i == 15 || i == 31) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_valid_%0d: got %b, expected 1", i, out_valid);
                end
            end
        end
        en = 1'b0;
        checks++;
        if (stalled !== 1'b0) begin
            failures++;
            $display("FAIL b2b_in_ready: in_ready dropped, expected always 1");
        end
        idle(2);
    endtask

    task automatic test_backpressure();
        logic [15:0] w1;
        w1 = 16'hA5C3;
        out_ready = 1'b0;
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(w1);
        for (int i = 0; i < 32; i++) begin
            drive((i < 16) ? 1'b1 : w1[i - 16], 4'd0, 1'b1);
            if (i == 30) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_ready_early: got %b, expected 1", in_ready);
                end
            end
        end
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_stall: got r=%b v=%b, expected r=0 v=1", in_ready, out_valid);
        end
        // Writes while stalled must be ignored entirely.
        for (int i = 0; i < 3; i++) drive(1'b0, 4'd0, 1'b0);
        en = 1'b0;
        checks++;
        if (dup_err !== 1'b0 || out_data !== 16'hFFFF || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold: got e=%b d=%h r=%b, expected e=0 d=ffff r=0",
                     dup_err, out_data, in_ready);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== w1) begin
            failures++;
            $display("FAIL bp_release: got v=%b r=%b d=%h, expected v=1 r=1 d=%h",
                     out_valid, in_ready, out_data, w1);
        end
        out_ready = 1'b1;
        idle(2);
    endtask

    task automatic test_flush();
        logic [15:0] pat, x, y;
        pat = 16'h3C96;
        x = 16'h1234;
        y = 16'hBEEF;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) drive(1'b1, 4'd0, 1'b1);
        flush = 1'b1;
        drive(1'b1, 4'd0, 1'b1);
        flush = 1'b0;
        exp_q.push_back(pat);
        for (int i = 0; i < 16; i++) begin
            drive(pat[i], 4'd0, 1'b1);
            if (i == 14) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_early: got v=%b after 15 writes, expected 0", out_valid);
                end
            end
        end
        en = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || dup_err !== 1'b0) begin
            failures++;
            $display("FAIL flush_word: got v=%b e=%b, expected v=1 e=0", out_valid, dup_err);
        end
        idle(2);
        // Flush must drop a stalled complete word but leave the output alone.
        out_ready = 1'b0;
        exp_q.push_back(x);
        for (int i = 0; i < 16; i++) drive(x[i], 4'd0, 1'b1);
        for (int i = 0; i < 16; i++) drive(y[i], 4'd0, 1'b1);
        en = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== x) begin
            failures++;
            $display("FAIL flush_pending: got r=%b v=%b d=%h, expected r=1 v=1 d=%h",
                     in_ready, out_valid, out_data, x);
        end
        out_ready = 1'b1;
        idle(3);
    endtask

    task automatic test_dup();
        out_ready = 1'b1;
        exp_q.push_back(16'h0008);
        drive(1'b0, 4'd3, 1'b0);
        drive(1'b1, 4'd3, 1'b0);
        checks++;
        if (dup_err !== 1'b1) begin
            failures++;
            $display("FAIL dup_set: got %b, expected 1", dup_err);
        end
        for (int s = 0; s < 16; s++) begin
            if (s != 3) begin
                drive(1'b0, 4'(s), 1'b0);
                if (s == 15) begin end
                else if (s == 14) begin
                    checks++;
                    if (out_valid !== 1'b0) begin
                        failures++;
                        $display("FAIL dup_early: got v=%b after 16 writes, expected 0", out_valid);
                    end
                end
            end
        end
        en = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0008 || dup_err !== 1'b1) begin
            failures++;
            $display("FAIL dup_word: got v=%b d=%h e=%b, expected v=1 d=0008 e=1",
                     out_valid, out_data, dup_err);
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        logic [15:0] pat;
        pat = 16'h5A0F;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) drive(1'b1, 4'd0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b0, 4'd0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        en = 1'b0;
        checks++;
        if ({out_valid, out_data, dup_err, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid: got v=%b d=%h e=%b r=%b, expected v=0 d=0000 e=0 r=1",
                     out_valid, out_data, dup_err, in_ready);
        end
        out_ready = 1'b1;
        exp_q.push_back(pat);
        for (int i = 0; i < 16; i++) begin
            drive(pat[i], 4'd0, 1'b1);
            if (i == 14) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_mid_early: got v=%b, expected 0", out_valid);
                end
            end
        end
        en = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_word: got v=%b, expected 1", out_valid);
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_auto_fill();
        test_addressed();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_dup();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL words_outstanding: got %0d left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
